// File: rtl/ram_ref_arb.sv
// DRAM owner arbiter: grants CPU RAM cycles or runs a CAS-before-RAS refresh, one per timer period.
// Outputs are registered from the next state, so a grant or strobe appears one edge after the deciding sample.
module ram_ref_arb #(
   parameter int RAS_CYC = 3,
   parameter int PRE_CYC = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic RefReq,
   input  logic RefUrg,
   input  logic RAMReq,
   output logic RAMGnt,
   output logic RefBusy,
   output logic RefCAS,
   output logic RefRAS,
   output logic RefDone,
   output logic RefMiss
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAM     = 3'd1,
      ST_REF_CAS = 3'd2,
      ST_REF_RAS = 3'd3,
      ST_REF_PRE = 3'd4
   } state_t;

   localparam logic [3:0] RAS_TC = 4'(RAS_CYC - 1);
   localparam logic [3:0] PRE_TC = 4'(PRE_CYC - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_done;
   logic       r_hist;
   logic       r_gnt;
   logic       r_busy;
   logic       r_cas;
   logic       r_ras;
   logic       r_done_p;
   logic       r_miss;

   logic       w_pend;
   logic       w_in_ref;
   logic       w_done_evt;
   logic       w_miss_set;
   logic       w_nxt_ref;

   always_comb begin
      w_next     = r_state;
      w_pend     = RefReq && !r_done;
      w_in_ref   = (r_state == ST_REF_CAS) || (r_state == ST_REF_RAS) ||
                   (r_state == ST_REF_PRE);
      w_done_evt = (r_state == ST_REF_PRE) && (r_cnt == PRE_TC);
      // An in-flight refresh counts as serving the period that just ended.
      w_miss_set = r_hist && !RefReq && !r_done && !w_in_ref;

      case (r_state)
         ST_IDLE: begin
            if (w_pend && RefUrg) begin
               w_next = ST_REF_CAS;
            end else if (RAMReq) begin
               w_next = ST_RAM;
            end else if (w_pend) begin
               w_next = ST_REF_CAS;
            end
         end
         ST_RAM: begin
            if (!RAMReq) begin
               w_next = ST_IDLE;
            end
         end
         ST_REF_CAS: w_next = ST_REF_RAS;
         ST_REF_RAS: begin
            if (r_cnt == RAS_TC) begin
               w_next = ST_REF_PRE;
            end
         end
         ST_REF_PRE: begin
            if (r_cnt == PRE_TC) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase

      w_nxt_ref = (w_next == ST_REF_CAS) || (w_next == ST_REF_RAS) ||
                  (w_next == ST_REF_PRE);

      // Counter restarts on every state entry and saturates instead of wrapping.
      w_cnt_nxt = r_cnt;
      if (w_next != r_state) begin
         w_cnt_nxt = 4'd0;
      end else if (r_cnt != 4'hF) begin
         w_cnt_nxt = r_cnt + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_done   <= 1'b0;
         r_hist   <= 1'b0;
         r_gnt    <= 1'b0;
         r_busy   <= 1'b0;
         r_cas    <= 1'b0;
         r_ras    <= 1'b0;
         r_done_p <= 1'b0;
         r_miss   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt_nxt;
         r_hist   <= RefReq;
         // A low RefReq sample clears Done even on the completion edge.
         if (!RefReq) begin
            r_done <= 1'b0;
         end else if (w_done_evt) begin
            r_done <= 1'b1;
         end
         r_gnt    <= (w_next == ST_RAM);
         r_busy   <= w_nxt_ref;
         r_cas    <= (w_next == ST_REF_CAS) || (w_next == ST_REF_RAS);
         r_ras    <= (w_next == ST_REF_RAS);
         r_done_p <= w_done_evt;
         r_miss   <= r_miss || w_miss_set;
      end
   end

   assign RAMGnt  = r_gnt;
   assign RefBusy = r_busy;
   assign RefCAS  = r_cas;
   assign RefRAS  = r_ras;
   assign RefDone = r_done_p;
   assign RefMiss = r_miss;

endmodule
